// File: rtl/dmem_responder.sv
// Fixed-latency memory responder for the data-cache port: byte-masked stores, registered loads.
// Optional tohost decode enabled by defining DMEM_TOHOST_EN.
module dmem_responder #(
  parameter int unsigned ADDR_W      = 12,
  parameter int unsigned LATENCY     = 2,
  parameter logic [31:0] TOHOST_ADDR = 32'h8000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] dcache_addr,
  input  logic        dcache_re,
  input  logic [3:0]  dcache_we,
  input  logic [31:0] dcache_din,
  output logic [31:0] dcache_dout,
  output logic        stall,
  output logic        oor,
  output logic [31:0] csr_tohost
);

  typedef enum logic [1:0] {StIdle, StWait, StDone} state_e;

  state_e      state_q;
  logic [7:0]  cnt_q;
  logic [29:0] addr_q;
  logic [3:0]  we_q;
  logic [31:0] din_q;
  logic [31:0] dout_q;
  logic        oor_q;

  logic [31:0] mem [2**ADDR_W];

  logic              req;
  logic              is_store;
  logic              access;
  logic              in_range;
  logic              tohost_hit;
  logic [ADDR_W-1:0] idx;
  logic [31:0]       wmask;
  logic [31:0]       load_data;
  logic              unused_addr;

  assign req         = dcache_re | (dcache_we != 4'b0000);
  assign is_store    = (we_q != 4'b0000);
  assign access      = (state_q == StWait) && (cnt_q == 8'd0);
  assign in_range    = ((addr_q >> ADDR_W) == '0);
  assign idx         = addr_q[ADDR_W-1:0];
  assign unused_addr = ^dcache_addr[1:0];

  always_comb begin
    wmask = '0;
    for (int i = 0; i < 4; i++) begin
      wmask[8*i +: 8] = {8{we_q[i]}};
    end
  end

`ifdef DMEM_TOHOST_EN
  logic [31:0] tohost_q;

  assign tohost_hit = (addr_q == TOHOST_ADDR[31:2]);
  assign csr_tohost = tohost_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tohost_q <= '0;
    end else if (access && is_store && tohost_hit) begin
      tohost_q <= (tohost_q & ~wmask) | (din_q & wmask);
    end
  end
`else
  logic unused_tohost;

  assign tohost_hit    = 1'b0;
  assign csr_tohost    = '0;
  assign unused_tohost = ^TOHOST_ADDR;
`endif

  // tohost decode takes priority over the range check
  assign load_data = tohost_hit ? csr_tohost : (in_range ? mem[idx] : 32'h0);

  // Reset gating keeps stall low even while a request is driven during reset
  assign stall = reset & (((state_q == StIdle) & req) | (state_q == StWait));

  assign dcache_dout = dout_q;
  assign oor         = oor_q;

  // Array is deliberately not reset; state is IDLE under reset so no write can fire
  always_ff @(posedge clk) begin
    if (access && is_store && in_range && !tohost_hit) begin
      for (int i = 0; i < 4; i++) begin
        if (we_q[i]) mem[idx][8*i +: 8] <= din_q[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      addr_q  <= '0;
      we_q    <= '0;
      din_q   <= '0;
      dout_q  <= '0;
      oor_q   <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (req) begin
            addr_q  <= dcache_addr[31:2];
            we_q    <= dcache_we;
            din_q   <= dcache_din;
            cnt_q   <= 8'(LATENCY - 1);
            state_q <= StWait;
          end
        end
        StWait: begin
          if (cnt_q != 8'd0) begin
            cnt_q <= cnt_q - 8'd1;
          end else begin
            oor_q   <= !in_range && !tohost_hit;
            state_q <= StDone;
            if (!is_store) dout_q <= load_data;
          end
        end
        StDone: begin
          oor_q   <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: a reference model pushes expected results at drive time,
// popped and compared in the DONE cycle.
module tb_dmem_responder;

  localparam int unsigned LAT    = 2;
  localparam int          PERIOD = 10;
  localparam logic [31:0] TOHOST = 32'h8000_0000;
`ifdef DMEM_TOHOST_EN
  localparam bit TOHOST_EN = 1'b1;
`else
  localparam bit TOHOST_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] addr = '0;
  logic        re = 1'b0;
  logic [3:0]  we = '0;
  logic [31:0] din = '0;
  logic [31:0] dout;
  logic        stall;
  logic        oor;
  logic [31:0] csr;

  dmem_responder #(
    .ADDR_W     (12),
    .LATENCY    (LAT),
    .TOHOST_ADDR(TOHOST)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .dcache_addr(addr),
    .dcache_re  (re),
    .dcache_we  (we),
    .dcache_din (din),
    .dcache_dout(dout),
    .stall      (stall),
    .oor        (oor),
    .csr_tohost (csr)
  );

  always #(PERIOD / 2) clk = ~clk;

  typedef struct {
    logic [31:0] dout;
    logic        oor;
    logic [31:0] tohost;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] model_mem [4096];
  logic [31:0] model_dout = '0;
  logic [31:0] model_tohost = '0;
  int          n_checks = 0;
  int          n_fail = 0;
  time         done_t = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                        input logic [3:0] w);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++) if (w[i]) r[8*i +: 8] = nw[8*i +: 8];
    return r;
  endfunction

  // Called at a negedge while the DUT is IDLE; returns at the IDLE negedge after DONE
  task automatic access(input string tag, input logic [31:0] a, input logic r,
                        input logic [3:0] w, input logic [31:0] d);
    exp_t e;
    exp_t got;
    int   n;
    logic hit;
    logic inr;
    hit = TOHOST_EN && (a[31:2] == TOHOST[31:2]);
    inr = (a[31:14] == 18'h0);
    if (w != 4'b0000) begin
      if (hit) model_tohost = merge(model_tohost, d, w);
      else if (inr) model_mem[a[13:2]] = merge(model_mem[a[13:2]], d, w);
    end else begin
      model_dout = hit ? model_tohost : (inr ? model_mem[a[13:2]] : 32'h0);
    end
    e.dout   = model_dout;
    e.oor    = !hit && !inr;
    e.tohost = model_tohost;
    exp_q.push_back(e);

    addr = a; re = r; we = w; din = d;
    #1;
    n = 0;
    while (stall && n < 20) begin
      n++;
      @(negedge clk);
    end
    done_t = $time;
    check({tag, "_stall_cycles"}, n, LAT + 1);
    got = exp_q.pop_front();
    check({tag, "_dout"}, dout, got.dout);
    check({tag, "_oor"}, {31'h0, oor}, {31'h0, got.oor});
    check({tag, "_tohost"}, csr, got.tohost);
    addr = '0; re = 1'b0; we = '0; din = '0;
    @(negedge clk);
    check({tag, "_oor_clear"}, {31'h0, oor}, 32'h0);
    check({tag, "_dout_hold"}, dout, got.dout);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    time prev_t;
    // reset state, with a load request driven during reset
    re = 1'b1; addr = 32'h40;
    #2;
    check("rst_stall", {31'h0, stall}, 32'h0);
    check("rst_dout", dout, 32'h0);
    check("rst_oor", {31'h0, oor}, 32'h0);
    check("rst_tohost", csr, 32'h0);
    re = 1'b0; addr = '0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    // fill words 0..7 with known data
    for (int i = 0; i < 8; i++) access("fill", 32'(i * 4), 1'b0, 4'hF, 32'h0100_0000 * i + 32'h1234_5670);

    access("st_beef", 32'h40, 1'b0, 4'hF, 32'hDEAD_BEEF);
    access("ld_beef", 32'h40, 1'b1, 4'h0, 32'h0);
    access("st_b0", 32'h40, 1'b0, 4'b0001, 32'h0000_00AA);
    access("ld_b0", 32'h40, 1'b1, 4'h0, 32'h0);
    check("partial_b0", dout, 32'hDEAD_BEAA);
    access("st_b3", 32'h40, 1'b0, 4'b1000, 32'h1100_0000);
    access("ld_b3", 32'h40, 1'b1, 4'h0, 32'h0);
    check("partial_b3", dout, 32'h11AD_BEAA);

    // out of range: bits above the index must not alias onto word 0
    access("ld_oor", 32'h0001_0000, 1'b1, 4'h0, 32'h0);
    access("st_oor", 32'h0001_0000, 1'b0, 4'hF, 32'hFFFF_FFFF);
    access("ld_w0", 32'h0, 1'b1, 4'h0, 32'h0);
    access("ld_w40", 32'h40, 1'b1, 4'h0, 32'h0);

    // load and store strobes together act as a store
    access("ldst", 32'h80, 1'b1, 4'hF, 32'h5A5A_5A5A);
    access("ld_80", 32'h80, 1'b1, 4'h0, 32'h0);

    // tohost
    access("st_tohost", TOHOST, 1'b0, 4'hF, 32'h0000_0001);
    access("ld_tohost", TOHOST, 1'b1, 4'h0, 32'h0);

    // back-to-back loads: one DONE every LAT+2 cycles
    access("b2b0", 32'h0, 1'b1, 4'h0, 32'h0);
    for (int i = 1; i < 5; i++) begin
      prev_t = done_t;
      access("b2b", 32'(i * 4), 1'b1, 4'h0, 32'h0);
      check("b2b_period", 32'(done_t - prev_t), (LAT + 2) * PERIOD);
    end

    // random traffic over the known words
    for (int i = 0; i < 16; i++) begin
      logic [31:0] a;
      a = 32'($urandom_range(0, 7) * 4);
      if ($urandom_range(0, 1) == 1) access("rnd_st", a, 1'b0, 4'($urandom_range(1, 15)), $urandom);
      else access("rnd_ld", a, 1'b1, 4'h0, 32'h0);
    end

    // reset mid-wait of a store to 0x10
    access("pre_ld", 32'h10, 1'b1, 4'h0, 32'h0);
    addr = 32'h10; we = 4'hF; din = 32'hCAFE_F00D;
    @(negedge clk);
    #2;
    reset = 1'b0;
    #1;
    check("midrst_stall", {31'h0, stall}, 32'h0);
    check("midrst_dout", dout, 32'h0);
    check("midrst_tohost", csr, 32'h0);
    model_dout = '0;
    model_tohost = '0;
    addr = '0; we = '0; din = '0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    access("post_rst_ld", 32'h10, 1'b1, 4'h0, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
